multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 35 +++
 rtl/multicycle_control.sv | 127 ++++++++++++
 2 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state codes, opcodes and mux/ALU encodings shared by the control and datapath
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EX     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11,
    TRAP     = 4'd12
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_SHL2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle MIPS datapath, with trap flag and retire counter
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        memToReg,
  output logic        regDst,
  output logic        regWrite,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  pcSource,
  output logic [3:0]  state,
  output logic        illegalOp,
  output logic [31:0] instrCount
);
  state_t cur, nxt;
  logic pw, iw, mr, mw, rw, retire;
  assign state = cur;
  always_comb begin
    nxt = FETCH;
    pw = 1'b0;
    iw = 1'b0;
    mr = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    iorD = 1'b0;
    memToReg = 1'b0;
    regDst = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = SRCB_REG;
    ALUOp = ALU_ADD;
    pcSource = PC_ALU;
    case (cur)
      FETCH: begin
        mr = 1'b1;
        aluSrcB = SRCB_ONE;
        pw = memReady;
        iw = memReady;
        nxt = memReady ? DECODE : FETCH;
      end
      DECODE: begin
        aluSrcB = SRCB_SHL2;
        nxt = (opcode == OP_R) ? R_EX :
              (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
              (opcode == OP_BEQ || opcode == OP_BNE) ? BRANCH :
              (opcode == OP_J) ? JUMP :
              (opcode == OP_ADDI) ? ADDI_EX : TRAP;
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_SEXT;
        nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mr = 1'b1;
        iorD = 1'b1;
        nxt = memReady ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        rw = 1'b1;
        memToReg = 1'b1;
      end
      MEM_WR: begin
        mw = 1'b1;
        iorD = 1'b1;
        nxt = memReady ? FETCH : MEM_WR;
      end
      R_EX: begin
        aluSrcA = 1'b1;
        ALUOp = ALU_FUNCT;
        nxt = R_WB;
      end
      R_WB: begin
        rw = 1'b1;
        regDst = 1'b1;
      end
      BRANCH: begin
        aluSrcA = 1'b1;
        ALUOp = ALU_SUB;
        pcSource = PC_ALUOUT;
        pw = (opcode == OP_BNE) ? !zero : zero;
      end
      JUMP: begin
        pcSource = PC_JUMP;
        pw = 1'b1;
      end
      ADDI_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_SEXT;
        nxt = ADDI_WB;
      end
      ADDI_WB: rw = 1'b1;
      TRAP: nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end
  // Write strobes are suppressed during reset so the datapath cannot be corrupted
  assign pcWrite  = pw & !rst;
  assign irWrite  = iw & !rst;
  assign memRead  = mr & !rst;
  assign memWrite = mw & !rst;
  assign regWrite = rw & !rst;
  assign retire = (nxt == FETCH) &&
                  (cur == MEM_WB || cur == MEM_WR || cur == R_WB ||
                   cur == ADDI_WB || cur == BRANCH || cur == JUMP);
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      illegalOp <= 1'b0;
      instrCount <= 32'd0;
    end else begin
      cur <= nxt;
      if (nxt == TRAP) illegalOp <= 1'b1;
      if (retire) instrCount <= instrCount + 32'd1;
    end
  end
endmodule
